// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg: shared state encoding and stage-valid bit positions for the hazard sequencer.
package hazard_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
  localparam int V_IFID = 2;
  localparam int V_IDEX = 1;
  localparam int V_EXWB = 0;
endpackage

// File: rtl/hazard_compare.sv
// hazard_compare: flags a read of one source specifier that matches either of two writing stage destinations.
module hazard_compare #(
  parameter int REGW = 6
) (
  input  logic [REGW-1:0] i_src,
  input  logic            i_uses,
  input  logic [REGW-1:0] i_rd_a,
  input  logic            i_wr_a,
  input  logic [REGW-1:0] i_rd_b,
  input  logic            i_wr_b,
  output logic            o_match
);
  assign o_match = i_uses & ((i_wr_a & (i_src == i_rd_a)) | (i_wr_b & (i_src == i_rd_b)));
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush control for a three-stage pipeline with stage-valid tracking and event counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REGW = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] in_rs,
  input  logic [REGW-1:0] in_rt,
  input  logic            in_ctrl_usesrs,
  input  logic            in_ctrl_usesrt,
  input  logic [REGW-1:0] in_idex_rd,
  input  logic            in_idex_ctrl_regwrt,
  input  logic [REGW-1:0] in_exwb_rd,
  input  logic            in_exwb_ctrl_regwrt,
  input  logic            in_ctrl_pcsel,
  output logic            out_ctrl_pcwrt,
  output logic            out_ctrl_ifidwrt,
  output logic            out_ctrl_ifidflush,
  output logic            out_ctrl_idexflush,
  output logic            out_ctrl_exwbflush,
  output logic            out_ctrl_pcsel,
  output logic [1:0]      out_state,
  output logic [2:0]      out_valid,
  output logic [CNTW-1:0] out_stallcnt,
  output logic [CNTW-1:0] out_flushcnt
);
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_valid, w_valid_nxt;
  logic [CNTW-1:0] r_stallcnt, r_flushcnt;
  logic            w_wr_idex, w_wr_exwb, w_match_rs, w_match_rt, w_hazard, w_take, w_stall;

  assign w_wr_idex = r_valid[V_IDEX] & in_idex_ctrl_regwrt;
  assign w_wr_exwb = r_valid[V_EXWB] & in_exwb_ctrl_regwrt;

  hazard_compare #(.REGW(REGW)) u_cmp_rs (
    .i_src(in_rs), .i_uses(in_ctrl_usesrs),
    .i_rd_a(in_idex_rd), .i_wr_a(w_wr_idex),
    .i_rd_b(in_exwb_rd), .i_wr_b(w_wr_exwb),
    .o_match(w_match_rs)
  );

  hazard_compare #(.REGW(REGW)) u_cmp_rt (
    .i_src(in_rt), .i_uses(in_ctrl_usesrt),
    .i_rd_a(in_idex_rd), .i_wr_a(w_wr_idex),
    .i_rd_b(in_exwb_rd), .i_wr_b(w_wr_exwb),
    .o_match(w_match_rt)
  );

  assign w_hazard = r_valid[V_IFID] & (w_match_rs | w_match_rt);
  assign w_take   = in_ctrl_pcsel & r_valid[V_EXWB];
  // a redirect squashes everything, so a simultaneous hazard is never acted on
  assign w_stall  = w_hazard & ~w_take;

  always_comb begin
    w_valid_nxt = w_take ? 3'b100 :
                  w_hazard ? {r_valid[V_IFID], 1'b0, r_valid[V_IDEX]} :
                  {1'b1, r_valid[V_IFID], r_valid[V_IDEX]};
    w_state_nxt = w_take ? ST_FLUSH : w_hazard ? ST_STALL : (|w_valid_nxt) ? ST_RUN : ST_EMPTY;
    out_ctrl_pcwrt     = ~rst & ~w_stall;
    out_ctrl_ifidwrt   = ~rst & ~w_stall;
    out_ctrl_ifidflush = rst | w_take;
    out_ctrl_idexflush = rst | w_take | w_hazard;
    out_ctrl_exwbflush = rst | w_take;
    out_ctrl_pcsel     = ~rst & w_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_valid    <= 3'b000;
      r_stallcnt <= '0;
      r_flushcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (w_stall && !(&r_stallcnt)) r_stallcnt <= r_stallcnt + CNTW'(1);
      if (w_take && !(&r_flushcnt)) r_flushcnt <= r_flushcnt + CNTW'(1);
    end
  end

  assign out_state    = r_state;
  assign out_valid    = r_valid;
  assign out_stallcnt = r_stallcnt;
  assign out_flushcnt = r_flushcnt;
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_hazard_sequencer;
  localparam int REGW = 6;
  localparam int CNTW = 4;
  localparam logic [5:0] RUNC = 6'b110000;
  localparam logic [5:0] STLC = 6'b000100;
  localparam logic [5:0] TAKC = 6'b111111;
  localparam logic [5:0] RSTC = 6'b001110;

  typedef struct packed {
    logic [5:0]      ctl;
    logic [1:0]      st;
    logic [2:0]      v;
    logic [CNTW-1:0] sc;
    logic [CNTW-1:0] fc;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [REGW-1:0] in_rs = '0, in_rt = '0, in_idex_rd = '0, in_exwb_rd = '0;
  logic in_ctrl_usesrs = 1'b0, in_ctrl_usesrt = 1'b0, in_idex_ctrl_regwrt = 1'b0;
  logic in_exwb_ctrl_regwrt = 1'b0, in_ctrl_pcsel = 1'b0;
  logic out_ctrl_pcwrt, out_ctrl_ifidwrt, out_ctrl_ifidflush, out_ctrl_idexflush;
  logic out_ctrl_exwbflush, out_ctrl_pcsel;
  logic [1:0] out_state;
  logic [2:0] out_valid;
  logic [CNTW-1:0] out_stallcnt, out_flushcnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0, n_bad = 0, stall_run = 0;
  bit    wd_en = 1'b1;

  hazard_sequencer #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_rs(in_rs), .in_rt(in_rt),
    .in_ctrl_usesrs(in_ctrl_usesrs), .in_ctrl_usesrt(in_ctrl_usesrt),
    .in_idex_rd(in_idex_rd), .in_idex_ctrl_regwrt(in_idex_ctrl_regwrt),
    .in_exwb_rd(in_exwb_rd), .in_exwb_ctrl_regwrt(in_exwb_ctrl_regwrt),
    .in_ctrl_pcsel(in_ctrl_pcsel),
    .out_ctrl_pcwrt(out_ctrl_pcwrt), .out_ctrl_ifidwrt(out_ctrl_ifidwrt),
    .out_ctrl_ifidflush(out_ctrl_ifidflush), .out_ctrl_idexflush(out_ctrl_idexflush),
    .out_ctrl_exwbflush(out_ctrl_exwbflush), .out_ctrl_pcsel(out_ctrl_pcsel),
    .out_state(out_state), .out_valid(out_valid),
    .out_stallcnt(out_stallcnt), .out_flushcnt(out_flushcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {out_ctrl_pcwrt, out_ctrl_ifidwrt, out_ctrl_ifidflush, out_ctrl_idexflush,
            out_ctrl_exwbflush, out_ctrl_pcsel, out_state, out_valid, out_stallcnt, out_flushcnt};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b st=%0d v=%b sc=%0d fc=%0d, want ctl=%b st=%0d v=%b sc=%0d fc=%0d",
                 nm, a.ctl, a.st, a.v, a.sc, a.fc, e.ctl, e.st, e.v, e.sc, e.fc);
      end
    end
    stall_run = (out_state == 2'd2) ? stall_run + 1 : 0;
    if (wd_en && stall_run >= 3) begin
      n_bad++;
      $display("FAIL watchdog: got %0d consecutive STALL cycles, want at most 2", stall_run);
    end
  end

  task automatic drive(input bit r, input bit [5:0] rs, input bit urs, input bit [5:0] rt, input bit urt,
                       input bit [5:0] idrd, input bit idw, input bit [5:0] exrd, input bit exw, input bit ps);
    rst = r; in_rs = rs; in_ctrl_usesrs = urs; in_rt = rt; in_ctrl_usesrt = urt;
    in_idex_rd = idrd; in_idex_ctrl_regwrt = idw; in_exwb_rd = exrd; in_exwb_ctrl_regwrt = exw;
    in_ctrl_pcsel = ps;
  endtask

  task automatic expect_step(input string nm, input logic [5:0] ctl, input logic [1:0] st,
                             input logic [2:0] v, input int sc, input int fc);
    exp_t e;
    e = {ctl, st, v, CNTW'(sc), CNTW'(fc)};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input bit ps);
    drive(r, 6'd1, 1'b0, 6'd2, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, ps);
  endtask

  task automatic dep_hold();
    drive(1'b0, 6'd5, 1'b1, 6'd9, 1'b0, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0);
  endtask

  initial begin
    idle(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_step("rst_hold", RSTC, 2'd0, 3'b000, 0, 0);
    idle(1'b0, 1'b0);
    expect_step("rel0", RUNC, 2'd0, 3'b000, 0, 0);
    expect_step("rel1", RUNC, 2'd1, 3'b100, 0, 0);
    expect_step("rel2", RUNC, 2'd1, 3'b110, 0, 0);
    expect_step("rel3", RUNC, 2'd1, 3'b111, 0, 0);
    drive(1'b0, 6'd5, 1'b1, 6'd2, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0, 1'b0);
    expect_step("dep_idex", STLC, 2'd1, 3'b111, 0, 0);
    drive(1'b0, 6'd5, 1'b1, 6'd2, 1'b0, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0);
    expect_step("dep_exwb", STLC, 2'd2, 3'b101, 1, 0);
    expect_step("dep_clear", RUNC, 2'd2, 3'b100, 2, 0);
    drive(1'b0, 6'd5, 1'b1, 6'd2, 1'b0, 6'd5, 1'b0, 6'd5, 1'b0, 1'b0);
    expect_step("no_regwrt", RUNC, 2'd1, 3'b110, 2, 0);
    drive(1'b0, 6'd5, 1'b0, 6'd7, 1'b1, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0);
    expect_step("no_usesrs", RUNC, 2'd1, 3'b111, 2, 0);
    idle(1'b0, 1'b1);
    expect_step("take", TAKC, 2'd1, 3'b111, 2, 0);
    expect_step("pcsel_unq", RUNC, 2'd3, 3'b100, 2, 1);
    idle(1'b0, 1'b0);
    expect_step("refill", RUNC, 2'd1, 3'b110, 2, 1);
    drive(1'b0, 6'd5, 1'b1, 6'd2, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0, 1'b1);
    expect_step("take_haz", TAKC, 2'd1, 3'b111, 2, 1);
    idle(1'b0, 1'b0);
    expect_step("post_th0", RUNC, 2'd3, 3'b100, 2, 2);
    expect_step("post_th1", RUNC, 2'd1, 3'b110, 2, 2);
    wd_en = 1'b0;
    dep_hold();
    for (int k = 0; k < 7; k++) begin
      expect_step("sat_a", STLC, 2'd1, (k == 0) ? 3'b111 : 3'b110, (2 + 2*k > 15) ? 15 : 2 + 2*k, 2);
      expect_step("sat_b", STLC, 2'd2, 3'b101, (3 + 2*k > 15) ? 15 : 3 + 2*k, 2);
      expect_step("sat_c", RUNC, 2'd2, 3'b100, (4 + 2*k > 15) ? 15 : 4 + 2*k, 2);
    end
    expect_step("sat_hold", STLC, 2'd1, 3'b110, 15, 2);
    drive(1'b1, 6'd5, 1'b1, 6'd9, 1'b0, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0);
    expect_step("rst_stall", RSTC, 2'd2, 3'b101, 15, 2);
    dep_hold();
    expect_step("after_rst", RUNC, 2'd0, 3'b000, 0, 0);
    wd_en = 1'b1;
    idle(1'b0, 1'b0);
    expect_step("fill1", RUNC, 2'd1, 3'b100, 0, 0);
    expect_step("fill2", RUNC, 2'd1, 3'b110, 0, 0);
    idle(1'b0, 1'b1);
    expect_step("take2", TAKC, 2'd1, 3'b111, 0, 0);
    idle(1'b1, 1'b0);
    expect_step("rst_flush", RSTC, 2'd3, 3'b100, 0, 1);
    idle(1'b0, 1'b0);
    expect_step("after_rst2", RUNC, 2'd0, 3'b000, 0, 0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter REGW, default 6, register-specifier width.
REQ-002 Parameter CNTW, default 16, event-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_rs, in_rt  input  REGW each  source specifiers of the instruction in IF/ID.
REQ-006 in_ctrl_usesrs, in_ctrl_usesrt  input  1 each  IF/ID instruction reads rs / rt.
REQ-007 in_idex_rd, in_idex_ctrl_regwrt  input  REGW, 1  destination and write-enable held in ID/EX.
REQ-008 in_exwb_rd, in_exwb_ctrl_regwrt  input  REGW, 1  destination and write-enable held in EX/WB.
REQ-009 in_ctrl_pcsel  input  1  PC-control "take branch/jump target" from the WB stage.
REQ-010 out_ctrl_pcwrt, out_ctrl_ifidwrt  output  1 each  PC / IF/ID load enables.
REQ-011 out_ctrl_ifidflush, out_ctrl_idexflush, out_ctrl_exwbflush  output  1 each  load a bubble (all ctrl bits 0) into that buffer at the next edge.
REQ-012 out_ctrl_pcsel  output  1  qualified target select to the PC mux.
REQ-013 out_state  output  2  FSM state; out_valid  output  3  {ifid, idex, exwb} stage-valid bits.
REQ-014 out_stallcnt, out_flushcnt  output  CNTW each  event counters.

Function
REQ-015 Valid tracking: the block SHALL keep valid bits v_ifid, v_idex, v_exwb; hazards and redirects are evaluated only against valid stages.
REQ-016 hazard SHALL equal v_ifid AND ((usesrs AND rs matches a valid writing stage's rd) OR (usesrt AND rt matches one)), where writing stage = (v_idex & idex_regwrt) or (v_exwb & exwb_regwrt).
REQ-017 take SHALL equal in_ctrl_pcsel AND v_exwb; out_ctrl_pcsel = take; unqualified pcsel is ignored.
REQ-018 take (priority over hazard): pcwrt=1, ifidwrt=1, all three flush outputs = 1; next valid = {1,0,0}.
REQ-019 hazard, no take: pcwrt=0, ifidwrt=0, idexflush=1, others 0; next valid = {v_ifid, 0, v_idex}.
REQ-020 Neither: pcwrt=1, ifidwrt=1, flushes 0; next valid = {1, v_ifid, v_idex}.
REQ-021 Control outputs SHALL be combinational from current inputs and valid bits (effective at the same edge); valid, state and counters are registered.
REQ-022 FSM states EMPTY=0, RUN=1, STALL=2, FLUSH=3; next = FLUSH on take, else STALL on hazard, else RUN if any next-valid bit set, else EMPTY.
REQ-023 A stall SHALL resolve unaided within 2 cycles; a third consecutive STALL cycle is a design error (bench assertion).
REQ-024 out_stallcnt increments each cycle hazard is acted on; out_flushcnt increments each take; both saturate at all-ones, never wrap.
REQ-025 Simultaneous take and hazard: count flush only.

Reset
REQ-026 While rst=1: valid=000, state=EMPTY, counters=0; combinational outputs forced pcwrt=0, ifidwrt=0, all flushes=1, pcsel=0.
REQ-027 rst asserted mid-stall or mid-flush SHALL discard that operation; first cycle after release behaves as EMPTY with fetch enabled.

Structure
REQ-028 State encoding and valid-bit index constants SHALL live in the shared CPU package.
REQ-029 One sub-module is natural: hazard_compare (one source specifier vs. two stage destinations, returns match); instantiated twice.

Verification
REQ-030 Reset release, no hazards, pcsel=0: valid 000->100->110->111 on successive cycles; state EMPTY->RUN; pcwrt=1 throughout.
REQ-031 Back-to-back dependency (IF/ID rs=5, ID/EX rd=5 regwrt=1, all valid): two STALL cycles (pcwrt=0, idexflush=1), then RUN; stallcnt=2.
REQ-032 pcsel=1 with v_exwb=1: all flushes=1, out_ctrl_pcsel=1, next valid=100, flushcnt=1; pcsel=1 with v_exwb=0: ignored.
REQ-033 take and hazard same cycle: flush wins, stallcnt unchanged, flushcnt+1.
REQ-034 Hazard against rd with regwrt=0, or usesrs=0: no stall.
REQ-035 Force stallcnt to all-ones via long hazard hold (watchdog disabled): stays all-ones; rst mid-stall clears counters and valid next cycle.
